// File: rtl/output_fifo_drain_ctrl_if.sv
// rtl/output_fifo_drain_ctrl_if.sv - signal bundle between the drain controller and its surroundings
//
// Groups the burst control, CIM write gate, FIFO lane pop and output stream
// signals of output_fifo_drain_ctrl.
//   slave  : view of the drain controller itself
//   master : view of the environment (CIM path, FIFO, host readout, sequencer)
// Signals:
//   start, cfg_len                burst request and entry count
//   busy, done                    burst status
//   cim_valid, cim_ready          CIM result handshake
//   fifo_wr_en                    gated FIFO write strobe
//   fifo_full, fifo_empty         FIFO status (OR of lanes)
//   fifo_rd_en, fifo_rd_data      one-hot lane pop and popped lane data
//   out_data/out_valid/out_ready/out_last  32b readout stream
//   stat_stall_cnt                output stall counter
interface output_fifo_drain_ctrl_if #(
  parameter int LEN_W  = 16,
  parameter int DATA_W = 32,
  parameter int STAT_W = 16
);
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic              busy;
  logic              done;
  logic              cim_valid;
  logic              cim_ready;
  logic              fifo_wr_en;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [STAT_W-1:0] stat_stall_cnt;

  modport slave (
    input  start, cfg_len, cim_valid, fifo_full, fifo_empty, fifo_rd_data, out_ready,
    output busy, done, cim_ready, fifo_wr_en, fifo_rd_en, out_data, out_valid, out_last,
           stat_stall_cnt
  );

  modport master (
    output start, cfg_len, cim_valid, fifo_full, fifo_empty, fifo_rd_data, out_ready,
    input  busy, done, cim_ready, fifo_wr_en, fifo_rd_en, out_data, out_valid, out_last,
           stat_stall_cnt
  );
endinterface

// File: rtl/output_fifo_drain_ctrl.sv
// rtl/output_fifo_drain_ctrl.sv - drain sequencer for the dual-lane CIM output FIFO
//
// Gates 64b CIM result writes against FIFO full, and drains a programmed
// number of 64b entries as a 32b valid/ready stream, low lane then high lane,
// by driving the FIFO's one-hot lane pop fifo_rd_en[1:0].
// Ports:
//   clk   : clock, all logic on posedge
//   rst   : synchronous active-high reset
//   bus   : output_fifo_drain_ctrl_if.slave (burst control, write gate,
//           lane pop, output stream, stall counter)
// Optional feature: define OUT_DRAIN_STATS_EN to count output stall cycles
// on stat_stall_cnt (saturating, cleared on reset and on accepted start);
// otherwise stat_stall_cnt is tied to zero.
module output_fifo_drain_ctrl #(
  parameter int LEN_W  = 16,
  parameter int DATA_W = 32,
  parameter int STAT_W = 16
) (
  input logic                      clk,
  input logic                      rst,
  output_fifo_drain_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              lane_q, lane_d;      // 0 = low lane word, 1 = high lane word
  logic [LEN_W-1:0]  cnt_q, cnt_d;        // entry index within the burst
  logic [LEN_W-1:0]  len_q, len_d;        // latched burst length
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic [1:0]        rd_en;
  logic              start_acc;
  logic              last_entry;

  // Write gate is independent of the drain FSM.
  assign bus.cim_ready  = ~bus.fifo_full;
  assign bus.fifo_wr_en = bus.cim_valid & ~bus.fifo_full;

  assign start_acc  = bus.start & (state_q == S_IDLE);
  // len_q is never zero inside a burst, so len_q-1 cannot underflow here.
  assign last_entry = (cnt_q == (len_q - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lane_q  <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    rd_en   = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          if (bus.cfg_len != '0) begin
            len_d   = bus.cfg_len;
            lane_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_REQ;
          end else begin
            // Zero-length burst: acknowledge immediately without going busy.
            done_d = 1'b1;
          end
        end
      end

      S_REQ: begin
        if (lane_q) begin
          // The low-lane pop committed this entry; the high lane is read
          // without looking at empty.
          rd_en   = 2'b10;
          data_d  = bus.fifo_rd_data;
          valid_d = 1'b1;
          last_d  = last_entry;
          state_d = S_HOLD;
        end else if (!bus.fifo_empty) begin
          rd_en   = 2'b01;
          data_d  = bus.fifo_rd_data;
          valid_d = 1'b1;
          last_d  = 1'b0;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (!lane_q) begin
            lane_d  = 1'b1;
            state_d = S_REQ;
          end else if (last_entry) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + LEN_W'(1);
            lane_d  = 1'b0;
            state_d = S_REQ;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_last   = last_q;

`ifdef OUT_DRAIN_STATS_EN
  logic [STAT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (valid_q && !bus.out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + STAT_W'(1);
    end
  end

  assign bus.stat_stall_cnt = stall_q;
`else
  assign bus.stat_stall_cnt = {STAT_W{1'b0}};
`endif

  // Lane pops are one-hot, and a stalled word must not move.
  a_rd_onehot: assert property (@(posedge clk) disable iff (rst) rd_en != 2'b11);
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (valid_q && !bus.out_ready) |=> (valid_q && $stable(data_q)));

endmodule

// File: tb/tb_output_fifo_drain_ctrl.sv
// tb/tb_output_fifo_drain_ctrl.sv - self-checking bench for output_fifo_drain_ctrl
module tb_output_fifo_drain_ctrl;
  localparam int LEN_W  = 16;
  localparam int DATA_W = 32;
  localparam int STAT_W = 16;
  localparam int DEPTH  = 4;
`ifdef OUT_DRAIN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  output_fifo_drain_ctrl_if #(.LEN_W(LEN_W), .DATA_W(DATA_W), .STAT_W(STAT_W)) bus();

  output_fifo_drain_ctrl #(.LEN_W(LEN_W), .DATA_W(DATA_W), .STAT_W(STAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- two-lane FIFO model ----------------
  logic [31:0] lo_mem [DEPTH];
  logic [31:0] hi_mem [DEPTH];
  logic [1:0]  wp = 2'd0, lo_rp = 2'd0, hi_rp = 2'd0;
  int          lo_n = 0, hi_n = 0;
  logic        force_full = 1'b0;
  logic        fifo_flush = 1'b0;
  logic [63:0] cim_data = '0;
  logic [31:0] exp_q[$];   // words in the order they must leave the stream

  assign bus.fifo_full    = force_full || (lo_n == DEPTH) || (hi_n == DEPTH);
  assign bus.fifo_empty   = (lo_n == 0) || (hi_n == 0);
  assign bus.fifo_rd_data = (bus.fifo_rd_en[0] === 1'b1) ? lo_mem[lo_rp] :
                            (bus.fifo_rd_en[1] === 1'b1) ? hi_mem[hi_rp] : 32'h0;

  always @(posedge clk) begin : fifo_model
    int wr, plo, phi;
    if (fifo_flush) begin
      wp <= 2'd0; lo_rp <= 2'd0; hi_rp <= 2'd0; lo_n <= 0; hi_n <= 0;
      exp_q.delete();
    end else begin
      wr  = (bus.fifo_wr_en === 1'b1) ? 1 : 0;
      plo = (bus.fifo_rd_en[0] === 1'b1) ? 1 : 0;
      phi = (bus.fifo_rd_en[1] === 1'b1) ? 1 : 0;
      if (wr != 0) begin
        lo_mem[wp] <= cim_data[31:0];
        hi_mem[wp] <= cim_data[63:32];
        wp <= wp + 2'd1;
        exp_q.push_back(cim_data[31:0]);
        exp_q.push_back(cim_data[63:32]);
      end
      if (plo != 0) lo_rp <= lo_rp + 2'd1;
      if (phi != 0) hi_rp <= hi_rp + 2'd1;
      lo_n <= lo_n + wr - plo;
      hi_n <= hi_n + wr - phi;
    end
  end

  // ---------------- burst-level reference model ----------------
  bit               mon_en = 1'b0;
  bit               busy_m = 1'b0;
  bit               done_m = 1'b0;
  logic [STAT_W-1:0] stall_m = '0;
  int               len_m = 0, word_idx = 0, pop_idx = 0;
  bit               stall_prev = 1'b0;
  logic [31:0]      data_prev = '0;
  logic [31:0]      exp_w;

  always @(negedge clk) begin : monitor
    bit hs, fin, acc;
    if (mon_en) begin
      chk("cim_ready", bus.cim_ready, !bus.fifo_full);
      chk("fifo_wr_en", bus.fifo_wr_en, bus.cim_valid && !bus.fifo_full);
      chk("rd_en_both", bus.fifo_rd_en == 2'b11, 0);
      chk("busy", bus.busy, busy_m);
      chk("done", bus.done, done_m);
      chk("stall_cnt", bus.stat_stall_cnt, stall_m);
      chk("valid_idle", bus.out_valid && !busy_m, 0);
      if (!bus.out_valid) chk("last_idle", bus.out_last, 0);
      if (stall_prev) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, data_prev);
      end
      if (bus.fifo_rd_en != 2'b00) begin
        chk("pop_idle", busy_m, 1);
        chk("pop_while_valid", bus.out_valid, 0);
        chk("pop_lane", bus.fifo_rd_en, (pop_idx % 2 == 1) ? 2'b10 : 2'b01);
        chk("pop_overrun", pop_idx < 2 * len_m, 1);
        if (bus.fifo_rd_en[0]) chk("pop_lo_empty", lo_n > 0, 1);
        if (bus.fifo_rd_en[1]) chk("pop_hi_empty", hi_n > 0, 1);
        pop_idx++;
      end
      hs  = bus.out_valid && bus.out_ready && !rst;
      fin = hs && (word_idx == 2 * len_m - 1);
      if (hs) begin
        chk("sb_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          chk("out_data", bus.out_data, exp_w);
        end
        chk("out_last", bus.out_last, fin);
        word_idx++;
      end
      acc = bus.start && !busy_m && !rst;
      if (rst) begin
        busy_m = 0; done_m = 0; stall_m = '0; stall_prev = 0;
        word_idx = 0; pop_idx = 0; len_m = 0;
      end else begin
        done_m = fin || (acc && (bus.cfg_len == '0));
        if (acc) begin
          stall_m  = '0;
          len_m    = int'(bus.cfg_len);
          word_idx = 0;
          pop_idx  = 0;
          busy_m   = (bus.cfg_len != '0);
        end else begin
          if (fin) busy_m = 0;
          if (STATS && bus.out_valid && !bus.out_ready && (stall_m != '1)) stall_m = stall_m + 1'b1;
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        data_prev  = bus.out_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    chk("idle_timeout", n < bound, 1);
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.cfg_len = '0; bus.cim_valid = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_stall", bus.stat_stall_cnt, 0);
    chk("rst_rd_en", bus.fifo_rd_en, 0);
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Two entries, full-rate drain.
    bus.cim_valid = 1'b1; cim_data = {32'hA1A1_0001, 32'hA0A0_0000}; tick();
    cim_data = {32'hB1B1_0011, 32'hB0B0_0010}; tick();
    bus.cim_valid = 1'b0; bus.out_ready = 1'b1; bus.start = 1'b1; bus.cfg_len = 16'd2; tick();
    bus.start = 1'b0; bus.cfg_len = 16'd7;
    @(negedge clk);
    chk("t1_busy", bus.busy, 1);
    chk("t1_valid_early", bus.out_valid, 0);
    tick();
    @(negedge clk);
    chk("t1_latency", bus.out_valid, 1);
    chk("t1_first", bus.out_data, 32'hA0A0_0000);
    wait_idle(50);

    // Empty FIFO for several cycles, then one write.
    bus.start = 1'b1; bus.cfg_len = 16'd1; tick();
    bus.start = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("t2_busy", bus.busy, 1);
    chk("t2_rd_en", bus.fifo_rd_en, 0);
    chk("t2_valid", bus.out_valid, 0);
    tick();
    bus.cim_valid = 1'b1; cim_data = {32'hC1C1_0101, 32'hC0C0_0100}; tick();
    bus.cim_valid = 1'b0;
    wait_idle(50);

    // Three stalled cycles on the first word.
    bus.cim_valid = 1'b1; cim_data = {32'hD1D1_1001, 32'hD0D0_1000}; tick();
    bus.cim_valid = 1'b0; bus.out_ready = 1'b0; bus.start = 1'b1; bus.cfg_len = 16'd1; tick();
    bus.start = 1'b0;
    tick(); tick(); tick(); tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid", bus.out_valid, 1);
    chk("t3_data", bus.out_data, 32'hD0D0_1000);
    chk("t3_lo_pops", lo_n, 0);
    chk("t3_hi_kept", hi_n, 1);
    chk("t3_stall", bus.stat_stall_cnt, STATS ? 3 : 0);
    wait_idle(50);
    chk("t3_stall_end", bus.stat_stall_cnt, STATS ? 3 : 0);

    // Write gate against full.
    force_full = 1'b1; bus.cim_valid = 1'b1; cim_data = {32'hE1E1_2001, 32'hE0E0_2000};
    @(negedge clk);
    chk("t4_wr_blocked", bus.fifo_wr_en, 0);
    chk("t4_ready_low", bus.cim_ready, 0);
    tick();
    force_full = 1'b0;
    @(negedge clk);
    chk("t4_wr_open", bus.fifo_wr_en, 1);
    chk("t4_ready_high", bus.cim_ready, 1);
    tick();
    bus.cim_valid = 1'b0;

    // Zero-length burst.
    bus.start = 1'b1; bus.cfg_len = 16'd0; tick();
    bus.start = 1'b0;
    @(negedge clk);
    chk("t5_done", bus.done, 1);
    chk("t5_busy", bus.busy, 0);
    chk("t5_rd_en", bus.fifo_rd_en, 0);
    tick();
    @(negedge clk);
    chk("t5_done_drop", bus.done, 0);
    chk("t5_rd_en2", bus.fifo_rd_en, 0);
    tick();

    // Reset while holding the low-lane word.
    bus.cim_valid = 1'b1; cim_data = {32'hF1F1_3001, 32'hF0F0_3000}; tick();
    bus.cim_valid = 1'b0; bus.out_ready = 1'b0; bus.start = 1'b1; bus.cfg_len = 16'd2; tick();
    bus.start = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_hold", bus.out_valid, 1);
    chk("t6_hold_data", bus.out_data, 32'hE0E0_2000);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_last", bus.out_last, 0);
    chk("t6_data", bus.out_data, 0);
    chk("t6_stall", bus.stat_stall_cnt, 0);
    chk("t6_rd_en", bus.fifo_rd_en, 0);
    chk("t6_hi_left", hi_n - lo_n, 1);
    tick();
    rst = 1'b0; fifo_flush = 1'b1; tick();
    fifo_flush = 1'b0; tick();
    chk("t6_idle", bus.busy, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.cim_valid = 1'($urandom_range(0, 1));
      cim_data      = {$urandom, $urandom};
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.start     = ($urandom_range(0, 7) == 0);
      bus.cfg_len   = LEN_W'($urandom_range(0, 5));
      force_full    = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.start = 1'b0; force_full = 1'b0; bus.out_ready = 1'b1; bus.cim_valid = 1'b1;
    wait_idle(400);
    bus.cim_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
